// File: rtl/arb3_pkg.sv
// Shared types and helpers for the 3-client arbiter request agent.
package arb3_pkg;

  localparam int N_CLI = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_GAP  = 2'd3
  } req_st_e;

  // True when more than one grant line is active in the same cycle.
  function automatic logic multi_hot(input logic [N_CLI-1:0] v);
    return (v & (v - N_CLI'(1))) != '0;
  endfunction

endpackage

// File: rtl/arb3_req_chan.sv
// One client channel: pending-job counter, request FSM, hold/gap down-counters and a
// sticky flag for grants that arrive while the channel is not requesting.
//
//   state   | meaning
//   IDLE    | no request; moves to REQ as soon as a job is pending
//   REQ     | req high, waiting for the grant
//   BUSY    | resource owned for HOLD cycles, done on the last one
//   GAP     | req low for GAP recovery cycles
module arb3_req_chan
  import arb3_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int HOLD  = 4,
  parameter int GAP   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_job,
  input  logic i_gnt,
  output logic o_req,
  output logic o_busy,
  output logic o_done,
  output logic o_pend_ovf,
  output logic o_err
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  req_st_e            r_st;
  logic [CNT_W-1:0]   r_pend;
  logic [HOLD_W-1:0]  r_hold;
  logic [GAP_W-1:0]   r_gap;
  logic               r_req;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic               r_err;

  logic               w_accept;
  logic               w_inc;
  logic               w_dec;
  logic               w_sat;
  logic               w_ovf_hit;
  logic               w_bad_gnt;
  logic [CNT_W-1:0]   w_pend_nxt;

  assign w_accept  = (r_st == ST_REQ) && i_gnt;
  assign w_inc     = i_job && !w_accept;
  assign w_dec     = w_accept && !i_job;
  assign w_sat     = (r_pend == PEND_MAX);
  assign w_ovf_hit = w_inc && w_sat;
  assign w_bad_gnt = i_gnt && ((r_st == ST_IDLE) || (r_st == ST_GAP));

  // A job landing together with a grant-accept cancels out, so saturation only
  // loses a job when nothing is being consumed in the same cycle.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_inc && !w_sat) begin
      w_pend_nxt = r_pend + CNT_W'(1);
    end else if (w_dec) begin
      w_pend_nxt = r_pend - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= ST_IDLE;
      r_pend <= '0;
      r_hold <= '0;
      r_gap  <= '0;
      r_req  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ovf  <= r_ovf | w_ovf_hit;
      r_err  <= r_err | w_bad_gnt;
      r_done <= 1'b0;
      case (r_st)
        ST_IDLE: begin
          if (w_pend_nxt != '0) begin
            r_st  <= ST_REQ;
            r_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (w_accept) begin
            r_st   <= ST_BUSY;
            r_busy <= 1'b1;
            r_hold <= HOLD_LOAD;
            r_done <= (HOLD_LOAD == '0);
          end
        end
        ST_BUSY: begin
          if (r_hold == '0) begin
            r_busy <= 1'b0;
            r_req  <= 1'b0;
            if (GAP == 0) begin
              r_st <= ST_IDLE;
            end else begin
              r_st  <= ST_GAP;
              r_gap <= GAP_LOAD;
            end
          end else begin
            r_hold <= r_hold - HOLD_W'(1);
            r_done <= (r_hold == HOLD_W'(1));
          end
        end
        ST_GAP: begin
          if (r_gap == '0) begin
            r_st <= ST_IDLE;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign o_req      = r_req;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_pend_ovf = r_ovf;
  assign o_err      = r_err;

endmodule

// File: rtl/arb3_req_agent.sv
// Request side of the 3-way arbiter: one channel per client plus a sticky
// protocol-error flag covering multi-hot grants and grants to idle clients.
module arb3_req_agent
  import arb3_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int HOLD  = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CLI-1:0] job,
  input  logic [N_CLI-1:0] gnt,
  output logic [N_CLI-1:0] req,
  output logic [N_CLI-1:0] busy,
  output logic [N_CLI-1:0] done,
  output logic [N_CLI-1:0] pend_ovf,
  output logic             proto_err
);

  logic             w_multi;
  logic [N_CLI-1:0] w_gnt_ok;
  logic [N_CLI-1:0] w_err;
  logic             r_multi_err;

  // A multi-hot grant is dropped entirely so no two clients ever own the resource.
  assign w_multi  = multi_hot(gnt);
  assign w_gnt_ok = w_multi ? '0 : gnt;

  for (genvar g = 0; g < N_CLI; g++) begin : g_chan
    arb3_req_chan #(
      .CNT_W (CNT_W),
      .HOLD  (HOLD),
      .GAP   (GAP)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_job      (job[g]),
      .i_gnt      (w_gnt_ok[g]),
      .o_req      (req[g]),
      .o_busy     (busy[g]),
      .o_done     (done[g]),
      .o_pend_ovf (pend_ovf[g]),
      .o_err      (w_err[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_multi_err <= 1'b0;
    end else begin
      r_multi_err <= r_multi_err | w_multi;
    end
  end

  assign proto_err = r_multi_err | (|w_err);

endmodule

// File: tb/tb_arb3_req_agent.sv
// Bench for arb3_req_agent: directed scenarios plus randomized traffic, every cycle
// compared against a timer-based behavioural model of the three clients.
module tb_arb3_req_agent;

  localparam int HOLD  = 4;
  localparam int GAP   = 1;
  localparam int CNT_W = 3;
  localparam int PMAX  = (1 << CNT_W) - 1;
  localparam int PERIOD = HOLD + GAP + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] job = 3'b000;
  logic [2:0] gnt = 3'b000;
  logic [2:0] req, busy, done, pend_ovf;
  logic       proto_err;

  int n_checks = 0;
  int n_fail = 0;
  int cyc_n = 0;

  // model: pending jobs, remaining busy cycles, remaining quiet cycles, requesting flag
  int m_pend[3];
  int m_busy[3];
  int m_q[3];
  bit m_want[3];
  bit m_ovf[3];
  bit m_err;

  int mon_cli = 0;
  bit mon_prev = 1'b0;
  int rise_at[$];

  arb3_req_agent #(.CNT_W(CNT_W), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .job       (job),
    .gnt       (gnt),
    .req       (req),
    .busy      (busy),
    .done      (done),
    .pend_ovf  (pend_ovf),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0;
      m_busy[i] = 0;
      m_q[i]    = 0;
      m_want[i] = 1'b0;
      m_ovf[i]  = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] ge;
    bit multi;
    int pn;
    bit acc;
    multi = ($countones(gnt) > 1);
    ge = multi ? 3'b000 : gnt;
    if (multi) m_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (gnt[i] && !m_want[i] && m_busy[i] == 0) m_err = 1'b1;
      acc = m_want[i] && ge[i];
      pn = m_pend[i];
      if (job[i] && !acc) begin
        if (pn == PMAX) m_ovf[i] = 1'b1;
        else pn++;
      end else if (acc && !job[i]) begin
        pn--;
      end
      if (m_busy[i] > 0) begin
        m_busy[i]--;
        if (m_busy[i] == 0) m_q[i] = GAP;
      end else if (m_want[i]) begin
        if (acc) begin
          m_want[i] = 1'b0;
          m_busy[i] = HOLD;
        end
      end else if (m_q[i] > 0) begin
        m_q[i]--;
      end else if (pn > 0) begin
        m_want[i] = 1'b1;
      end
      m_pend[i] = pn;
    end
  endtask

  task automatic compare_all();
    logic [2:0] er, eb, ed, eo;
    for (int i = 0; i < 3; i++) begin
      er[i] = m_want[i] || (m_busy[i] > 0);
      eb[i] = (m_busy[i] > 0);
      ed[i] = (m_busy[i] == 1);
      eo[i] = m_ovf[i];
    end
    check("req", {5'b0, req}, {5'b0, er});
    check("busy", {5'b0, busy}, {5'b0, eb});
    check("done", {5'b0, done}, {5'b0, ed});
    check("pend_ovf", {5'b0, pend_ovf}, {5'b0, eo});
    check("proto_err", {7'b0, proto_err}, {7'b0, m_err});
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    cyc_n++;
    #1;
    compare_all();
    if (busy[mon_cli] && !mon_prev) rise_at.push_back(cyc_n);
    mon_prev = busy[mon_cli];
  endtask

  // Asserts reset between clock edges and checks outputs clear without a clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    job = 3'b000;
    gnt = 3'b000;
    #1;
    model_reset();
    compare_all();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic polite_gnt(input logic [2:0] mask);
    logic [2:0] cand;
    int start, idx;
    cand = req & ~busy & mask;
    gnt = 3'b000;
    if (cand != 3'b000 && $urandom_range(0, 1) == 1) begin
      start = $urandom_range(0, 2);
      for (int j = 0; j < 3; j++) begin
        idx = (start + j) % 3;
        if (cand[idx]) begin
          gnt[idx] = 1'b1;
          break;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    compare_all();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // single job, grant two cycles later
    job = 3'b001;
    cyc();
    job = 3'b000;
    check("t1_req_at1", {7'b0, req[0]}, 8'd1);
    cyc();
    gnt = 3'b001;
    cyc();
    gnt = 3'b000;
    check("t1_busy_at3", {7'b0, busy[0]}, 8'd1);
    cyc();
    cyc();
    cyc();
    check("t1_done_at6", {7'b0, done[0]}, 8'd1);
    check("t1_req_at6", {7'b0, req[0]}, 8'd1);
    cyc();
    check("t1_req_drop_at7", {7'b0, req[0]}, 8'd0);

    // three jobs with grant tied high
    do_reset();
    mon_cli = 1;
    mon_prev = 1'b0;
    rise_at.delete();
    gnt = 3'b010;
    for (int k = 0; k < 3; k++) begin
      job = 3'b010;
      cyc();
    end
    job = 3'b000;
    for (int k = 0; k < 30; k++) cyc();
    gnt = 3'b000;
    check("t2_windows", 8'(rise_at.size()), 8'd3);
    if (rise_at.size() >= 3) begin
      check("t2_space1", 8'(rise_at[1] - rise_at[0]), 8'(PERIOD));
      check("t2_space2", 8'(rise_at[2] - rise_at[1]), 8'(PERIOD));
    end

    // saturate client 2 with no grant
    do_reset();
    for (int k = 0; k < 8; k++) begin
      job = 3'b100;
      cyc();
      if (k == 6) check("t3_no_ovf_at7", {7'b0, pend_ovf[2]}, 8'd0);
    end
    job = 3'b000;
    cyc();
    check("t3_ovf", {7'b0, pend_ovf[2]}, 8'd1);
    check("t3_req_held", {7'b0, req[2]}, 8'd1);

    // multi-hot grant, then grant to an idle client
    do_reset();
    job = 3'b011;
    cyc();
    job = 3'b000;
    cyc();
    gnt = 3'b011;
    cyc();
    gnt = 3'b000;
    check("t4_multi_err", {7'b0, proto_err}, 8'd1);
    check("t4_multi_ignored", {5'b0, busy}, 8'd0);
    do_reset();
    cyc();
    check("t4_clear", {7'b0, proto_err}, 8'd0);
    gnt = 3'b001;
    cyc();
    gnt = 3'b000;
    check("t4_idle_gnt_err", {7'b0, proto_err}, 8'd1);
    check("t4_idle_gnt_ignored", {7'b0, busy[0]}, 8'd0);

    // job and accept in the same cycle with two pending
    do_reset();
    mon_cli = 0;
    mon_prev = 1'b0;
    rise_at.delete();
    job = 3'b001;
    cyc();
    cyc();
    gnt = 3'b001;
    cyc();
    job = 3'b000;
    gnt = 3'b000;
    check("t5_busy", {7'b0, busy[0]}, 8'd1);
    for (int k = 0; k < 40; k++) begin
      gnt = {2'b00, req[0] & ~busy[0]};
      cyc();
    end
    gnt = 3'b000;
    check("t5_windows", 8'(rise_at.size()), 8'd3);

    // reset while busy
    do_reset();
    job = 3'b001;
    cyc();
    job = 3'b000;
    gnt = 3'b001;
    cyc();
    gnt = 3'b000;
    cyc();
    check("t6_busy_before", {7'b0, busy[0]}, 8'd1);
    do_reset();
    check("t6_req_rst", {5'b0, req}, 8'd0);
    check("t6_busy_rst", {5'b0, busy}, 8'd0);
    for (int k = 0; k < 6; k++) cyc();
    check("t6_stay_idle", {5'b0, req}, 8'd0);

    // random traffic, well-behaved arbiter
    do_reset();
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < 3; i++) job[i] = ($urandom_range(0, 5) == 0);
      polite_gnt(3'b111);
      cyc();
    end
    check("rand_clean_err", {7'b0, proto_err}, 8'd0);

    // random traffic with occasional bad grants and one mid-run reset
    do_reset();
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < 3; i++) job[i] = ($urandom_range(0, 4) == 0);
      polite_gnt(3'b111);
      if ($urandom_range(0, 15) == 0) gnt = 3'($urandom_range(0, 7));
      if (k == 250) do_reset();
      cyc();
    end
    job = 3'b000;
    gnt = 3'b000;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
